// File: rtl/gen_trafico_qos.sv
// Traffic generator: writes num_words words into the Main FIFO in RR / fixed / LFSR class modes.
// Latency: first word presented the cycle after start, then one word per (gap+1) cycles when unblocked.
// Backpressure: main_full (and main_almost_full when AF_STOP) drop Main_wr combinationally; stalls are counted.
module gen_trafico_qos #(
  parameter int          BW        = 6,
  parameter int          CLASS_W   = 2,
  parameter int          CNT_W     = 8,
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter int          AF_STOP   = 1
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_start,
  input  logic [1:0]                       i_mode,
  input  logic [CLASS_W-1:0]               i_class_sel,
  input  logic [CNT_W-1:0]                 i_num_words,
  input  logic [3:0]                       i_gap,
  input  logic                             i_main_full,
  input  logic                             i_main_almost_full,
  output logic                             o_main_wr,
  output logic [BW-1:0]                    o_main_data_in,
  output logic                             o_busy,
  output logic                             o_done,
  output logic [(2**CLASS_W)*CNT_W-1:0]    o_sent_cnt,
  output logic [CNT_W-1:0]                 o_stall_cnt
);

  localparam int NCLASS = 2**CLASS_W;
  localparam bit AF_EN  = (AF_STOP != 0);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_mode;
  logic [CLASS_W-1:0]   r_class_sel;
  logic [CNT_W-1:0]     r_num_words;
  logic [3:0]           r_gap;
  logic [3:0]           r_gap_cnt;
  logic [CNT_W-1:0]     r_idx;
  logic [7:0]           r_lfsr;
  logic [BW-1:0]        r_data;
  logic [CNT_W-1:0]     r_sent [NCLASS];
  logic [CNT_W-1:0]     r_stall;

  logic                 w_wr;
  logic [CNT_W-1:0]     w_idx_nxt;
  logic [7:0]           w_lfsr_nxt;
  logic [CLASS_W-1:0]   w_cls;

  // Word builder: mode 2 takes LFSR bits, mode 1 a fixed class, anything else round-robin on idx.
  function automatic logic [BW-1:0] f_word(input logic [1:0]         m,
                                           input logic [CLASS_W-1:0] cs,
                                           input logic [CNT_W-1:0]   idx,
                                           input logic [7:0]         lf);
    logic [BW-1:0] w;
    case (m)
      2'd1:    w = {cs, idx[BW-CLASS_W-1:0]};
      2'd2:    w = lf[BW-1:0];
      default: w = {idx[CLASS_W-1:0], idx[BW-CLASS_W-1:0]};
    endcase
    return w;
  endfunction

  // Write strobe only depends on registered state and the two FIFO flags, so a flag drop stops writes at once.
  assign w_wr       = (r_state == S_SEND) & ~i_main_full & ~(AF_EN & i_main_almost_full);
  assign w_idx_nxt  = r_idx + CNT_W'(1);
  assign w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_cls      = r_data[BW-1 -: CLASS_W];

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = (i_num_words != '0) ? S_SEND : S_DONE;
      end
      S_SEND: begin
        if (w_wr) begin
          if (w_idx_nxt == r_num_words) w_state_nxt = S_DONE;
          else if (r_gap != 4'd0)       w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt <= 4'd1) w_state_nxt = S_SEND;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_main_wr = w_wr;
    o_busy    = (r_state == S_SEND) || (r_state == S_GAP);
    o_done    = (r_state == S_DONE);
  end

  // Datapath: latch run parameters on start, advance word/counters on each accepted write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mode      <= 2'd0;
      r_class_sel <= '0;
      r_num_words <= '0;
      r_gap       <= 4'd0;
      r_gap_cnt   <= 4'd0;
      r_idx       <= '0;
      r_lfsr      <= LFSR_SEED;
      r_data      <= '0;
      r_stall     <= '0;
      for (int k = 0; k < NCLASS; k++) r_sent[k] <= '0;
    end else begin
      if (r_state == S_IDLE && i_start) begin
        r_mode      <= i_mode;
        r_class_sel <= i_class_sel;
        r_num_words <= i_num_words;
        r_gap       <= i_gap;
        r_idx       <= '0;
        r_lfsr      <= LFSR_SEED;
        r_data      <= f_word(i_mode, i_class_sel, '0, LFSR_SEED);
        r_stall     <= '0;
        for (int k = 0; k < NCLASS; k++) r_sent[k] <= '0;
      end
      if (w_wr) begin
        r_idx         <= w_idx_nxt;
        r_lfsr        <= w_lfsr_nxt;
        r_data        <= f_word(r_mode, r_class_sel, w_idx_nxt, w_lfsr_nxt);
        r_sent[w_cls] <= r_sent[w_cls] + CNT_W'(1);
        r_gap_cnt     <= r_gap;
      end else if (r_state == S_GAP) begin
        r_gap_cnt     <= r_gap_cnt - 4'd1;
      end
      if (r_state == S_SEND && !w_wr && r_stall != '1) r_stall <= r_stall + CNT_W'(1);
    end
  end

  // Flatten per-class counters onto the packed output bus.
  always_comb begin
    o_sent_cnt = '0;
    for (int k = 0; k < NCLASS; k++) o_sent_cnt[k*CNT_W +: CNT_W] = r_sent[k];
  end

  assign o_main_data_in = r_data;
  assign o_stall_cnt    = r_stall;

endmodule

// File: tb/tb_gen_trafico_qos.sv
module tb_gen_trafico_qos;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [1:0]  class_sel;
  logic [7:0]  num_words;
  logic [3:0]  gap;
  logic        full;
  logic        afull;
  logic        wr;
  logic [5:0]  data;
  logic        busy;
  logic        done;
  logic [31:0] sent;
  logic [7:0]  stall;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_wr = 0;
  int start_cyc = 0;
  int dcyc = 0;
  logic [5:0]  exp_q[$];
  int          wr_cyc[$];
  logic [5:0]  wr_dat[$];
  logic [31:0] exp_sent;

  gen_trafico_qos dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_mode(mode),
    .i_class_sel(class_sel), .i_num_words(num_words), .i_gap(gap),
    .i_main_full(full), .i_main_almost_full(afull),
    .o_main_wr(wr), .o_main_data_in(data), .o_busy(busy), .o_done(done),
    .o_sent_cnt(sent), .o_stall_cnt(stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_adv(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [5:0] model_word(input logic [1:0] m, input logic [1:0] cs,
                                            input int idx, input logic [7:0] l);
    logic [7:0] iv;
    iv = idx[7:0];
    if (m == 2'd2)      return l[5:0];
    else if (m == 2'd1) return {cs, iv[3:0]};
    else                return {iv[1:0], iv[3:0]};
  endfunction

  // Monitor: every accepted write is compared against the scoreboard head.
  always @(negedge clk) begin
    if (wr && !rst) begin
      n_wr++;
      wr_cyc.push_back(cyc);
      wr_dat.push_back(data);
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("data", 32'(data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the start edge.
  task automatic start_run(input logic [1:0] m, input logic [1:0] cs, input int n, input int g);
    logic [7:0] l;
    logic [5:0] w;
    l = 8'hA5;
    exp_sent = '0;
    for (int i = 0; i < n; i++) begin
      w = model_word(m, cs, i, l);
      exp_q.push_back(w);
      exp_sent[w[5:4]*8 +: 8] = exp_sent[w[5:4]*8 +: 8] + 8'd1;
      l = lfsr_adv(l);
    end
    wr_cyc.delete();
    wr_dat.delete();
    n_wr      = 0;
    mode      = m;
    class_sel = cs;
    num_words = n[7:0];
    gap       = g[3:0];
    start     = 1'b1;
    tick(1);
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        dcyc  = cyc;
      end
    end
    check({tag, "_done_seen"}, 32'(found), 32'd1);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; class_sel = 2'd0;
    num_words = 8'd0; gap = 4'd0; full = 1'b0; afull = 1'b0;
    tick(3);
    rst = 1'b0;

    // Reset / idle
    @(negedge clk);
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_sent", sent, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    tick(10);
    check("idle_no_writes", 32'(n_wr), 32'd0);

    // Mode 0, 8 words back-to-back
    start_run(2'd0, 2'd0, 8, 0);
    wait_done("m0");
    check("m0_writes", 32'(n_wr), 32'd8);
    check("m0_first_latency", 32'(wr_cyc[0]), 32'(start_cyc));
    check("m0_consecutive", 32'(wr_cyc[7] - wr_cyc[0]), 32'd7);
    check("m0_word1", 32'(wr_dat[1]), 32'h11);
    check("m0_word4", 32'(wr_dat[4]), 32'h04);
    check("m0_done_timing", 32'(dcyc), 32'(wr_cyc[7] + 1));
    check("m0_sent", sent, 32'h0202_0202);
    check("m0_stall", 32'(stall), 32'd0);
    tick(1);

    // Mode 1, class 2, gap 2
    start_run(2'd1, 2'd2, 5, 2);
    wait_done("m1");
    check("m1_writes", 32'(n_wr), 32'd5);
    for (int i = 0; i < 4; i++) check("m1_spacing", 32'(wr_cyc[i+1] - wr_cyc[i]), 32'd3);
    check("m1_sent", sent, exp_sent);
    check("m1_sent_c2", 32'(sent[23:16]), 32'd5);
    check("m1_stall", 32'(stall), 32'd0);
    tick(1);

    // Backpressure: almost-full, then full
    for (int p = 0; p < 2; p++) begin
      start_run(2'd0, 2'd0, 6, 0);
      tick(2);
      check("bp_writes_before", 32'(n_wr), 32'd2);
      if (p == 0) afull = 1'b1; else full = 1'b1;
      @(negedge clk);
      check("bp_wr_blocked", 32'(wr), 32'd0);
      tick(4);
      afull = 1'b0; full = 1'b0;
      wait_done("bp");
      check("bp_writes", 32'(n_wr), 32'd6);
      check("bp_stall", 32'(stall), 32'd4);
      check("bp_sent", sent, 32'h0101_0202);
      tick(1);
    end

    // Mode 2 (LFSR) with an ignored mid-run start
    start_run(2'd2, 2'd0, 4, 0);
    tick(1);
    start = 1'b1; mode = 2'd0; num_words = 8'd1;
    tick(1);
    start = 1'b0;
    wait_done("m2");
    check("m2_writes", 32'(n_wr), 32'd4);
    check("m2_first", 32'(wr_dat[0]), 32'h25);
    check("m2_sent", sent, exp_sent);
    tick(5);
    check("m2_no_restart", 32'(n_wr), 32'd4);

    // Reset mid-run after 3rd write, then a zero-length run
    start_run(2'd0, 2'd0, 10, 0);
    tick(3);
    check("rr_writes_before", 32'(n_wr), 32'd3);
    rst = 1'b1;
    tick(1);
    exp_q.delete();
    @(negedge clk);
    check("rr_wr", 32'(wr), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_sent", sent, 32'd0);
    check("rr_stall", 32'(stall), 32'd0);
    check("rr_data", 32'(data), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    start_run(2'd0, 2'd0, 0, 0);
    wait_done("z");
    check("z_done_timing", 32'(dcyc), 32'(start_cyc));
    check("z_no_writes", 32'(n_wr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
